bcd_to_bin_seq: RTL and testbench

Sequential multi-digit BCD-to-binary decoder. It is the decode side of the cascaded BCD decade counters: it takes a packed snapshot of the decade digits (ones/tens/hundreds/...) and returns the equivalent unsigned binary value. It is used by logic downstream of the counters that needs a binary count for compares and arithmetic. It converts one digit per cycle, most significant digit first, using Horner accumulation (acc = acc*10 + digit), and uses a start/busy/done handshake.

---
 rtl/bcd_to_bin_seq.sv | 94 +++++++++
 tb/tb_bcd_to_bin_seq.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary decoder: one digit per cycle, MSD first, Horner accumulation.
// Optional per-digit range check enabled by defining BCD_DIGIT_CHECK_EN.
module bcd_to_bin_seq #(
  parameter int unsigned DIGITS = 3,
  parameter int unsigned BIN_W  = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [4*DIGITS-1:0] bcd_in,
  output logic                busy,
  output logic                done,
  output logic [BIN_W-1:0]    bin_out,
  output logic                err
);

  localparam int unsigned CntW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {StIdle, StConv} state_t;

  state_t              state;
  logic [4*DIGITS-1:0] shreg;
  logic [BIN_W-1:0]    acc;
  logic [BIN_W-1:0]    acc_nxt;
  logic [CntW-1:0]     cnt;
  logic [3:0]          nib;
  logic                last;

  // acc*10 as shift-add, wrapping modulo 2^BIN_W
  always_comb begin
    nib     = shreg[4*DIGITS-1 -: 4];
    acc_nxt = (acc << 3) + (acc << 1) + BIN_W'(nib);
    last    = (cnt == CntW'(DIGITS - 1));
  end

`ifdef BCD_DIGIT_CHECK_EN
  logic flag;
  logic bad;
  assign bad = (nib > 4'd9);
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= StIdle;
      shreg   <= '0;
      acc     <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bin_out <= '0;
`ifdef BCD_DIGIT_CHECK_EN
      flag    <= 1'b0;
      err     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            shreg <= bcd_in;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= StConv;
`ifdef BCD_DIGIT_CHECK_EN
            flag  <= 1'b0;
`endif
          end
        end
        StConv: begin
          acc   <= acc_nxt;
          shreg <= shreg << 4;
          cnt   <= cnt + CntW'(1);
`ifdef BCD_DIGIT_CHECK_EN
          flag  <= flag | bad;
`endif
          if (last) begin
            bin_out <= acc_nxt;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= StIdle;
`ifdef BCD_DIGIT_CHECK_EN
            err     <= flag | bad;
`endif
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Scoreboard bench for bcd_to_bin_seq: default 3-digit instance plus a 4-digit instance.
module tb_bcd_to_bin_seq;

  typedef struct {
    logic [13:0] bin;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, start4;
  logic [11:0] bcd_in;
  logic [15:0] bcd4;
  logic        busy, done, err, busy4, done4, err4;
  logic [9:0]  bin_out;
  logic [13:0] bin4;

  exp_t q3[$];
  exp_t q4[$];
  int   n_chk  = 0;
  int   n_fail = 0;

`ifdef BCD_DIGIT_CHECK_EN
  localparam logic ErrBad = 1'b1;
`else
  localparam logic ErrBad = 1'b0;
`endif

  always #5 clk = ~clk;

  bcd_to_bin_seq dut (
    .clk(clk), .reset(reset), .start(start), .bcd_in(bcd_in),
    .busy(busy), .done(done), .bin_out(bin_out), .err(err)
  );

  bcd_to_bin_seq #(.DIGITS(4), .BIN_W(14)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .bcd_in(bcd4),
    .busy(busy4), .done(done4), .bin_out(bin4), .err(err4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: pop one expectation per done pulse
  always @(negedge clk) begin
    if (!reset && done) begin
      if (q3.size() == 0) begin
        check("unexpected_done", 32'(done), 32'(0));
      end else begin
        exp_t e;
        e = q3.pop_front();
        check("bin_out", 32'(bin_out), 32'(e.bin));
        check("err", 32'(err), 32'(e.err));
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && done4) begin
      if (q4.size() == 0) begin
        check("unexpected_done4", 32'(done4), 32'(0));
      end else begin
        exp_t e;
        e = q4.pop_front();
        check("bin_out4", 32'(bin4), 32'(e.bin));
        check("err4", 32'(err4), 32'(e.err));
      end
    end
  end

  // Issue one 3-digit conversion and verify busy/done timing cycle by cycle
  task automatic run_conv(input logic [11:0] bcd, input logic [13:0] eb, input logic ee);
    bcd_in = bcd;
    start  = 1'b1;
    q3.push_back('{bin: eb, err: ee});
    tick();
    start  = 1'b0;
    bcd_in = 12'hFFF;
    check("busy_after_start", 32'(busy), 32'(1));
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("done_timing", 32'(done), 32'(i == 3));
      check("busy_timing", 32'(busy), 32'(i < 3));
    end
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    start4 = 1'b0;
    bcd_in = '0;
    bcd4   = '0;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_bin", 32'(bin_out), 32'(0));
    check("rst_err", 32'(err), 32'(0));
    reset = 1'b0;
    tick();

    run_conv(12'h123, 14'd123, 1'b0);
    tick();
    check("done_single_pulse", 32'(done), 32'(0));
    check("bin_held", 32'(bin_out), 32'(123));

    // start held high: 999 accepted, then 000 accepted on the done cycle
    q3.push_back('{bin: 14'd999, err: 1'b0});
    q3.push_back('{bin: 14'd0, err: 1'b0});
    bcd_in = 12'h999;
    start  = 1'b1;
    tick();
    bcd_in = 12'h000;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 4) start = 1'b0;
      check("b2b_done", 32'(done), 32'((i == 3) || (i == 7)));
    end

    run_conv(12'h1A5, 14'd205, ErrBad);
    run_conv(12'h042, 14'd42, 1'b0);

    // start while busy is ignored
    q3.push_back('{bin: 14'd321, err: 1'b0});
    bcd_in = 12'h321;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    bcd_in = 12'h777;
    tick();
    start  = 1'b1;
    tick();
    start  = 1'b0;
    tick();
    check("ignored_done", 32'(done), 32'(1));
    for (int i = 0; i < 4; i++) begin
      tick();
      check("no_second_conv", 32'(done | busy), 32'(0));
    end
    check("ignored_bin", 32'(bin_out), 32'(321));

    // reset mid-conversion aborts with no done
    bcd_in = 12'h555;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    reset  = 1'b1;
    #2;
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_done", 32'(done), 32'(0));
    check("abort_bin", 32'(bin_out), 32'(0));
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort_no_done", 32'(done), 32'(0));
    end

    // 4-digit instance
    bcd4   = 16'h9999;
    start4 = 1'b1;
    q4.push_back('{bin: 14'd9999, err: 1'b0});
    tick();
    start4 = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("d4_done_timing", 32'(done4), 32'(i == 4));
    end
    bcd4   = 16'h1234;
    start4 = 1'b1;
    q4.push_back('{bin: 14'd1234, err: 1'b0});
    tick();
    start4 = 1'b0;
    for (int i = 1; i <= 5; i++) tick();

    check("q3_drained", 32'(q3.size()), 32'(0));
    check("q4_drained", 32'(q4.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1, "watchdog expired");
  end

endmodule
